// File: rtl/servo_frame_scheduler.sv
// Four-channel servo pulse scheduler: one shared frame counter, four fixed slots,
// slew-limited positions ramping toward targets written over a valid/ready port.
//
// state  | meaning
// S_IDLE | frame counter parked at 0, outputs low, waiting for enable
// S_RUN  | frames generated back to back; enable sampled only at the wrap

module servo_frame_scheduler #(
    parameter int FRAME_CYCLES = 200000,
    parameter int SLOT_CYCLES  = 50000,
    parameter int MIN_PULSE    = 10000,
    parameter int STEP         = 40,
    parameter int SLEW         = 4,
    parameter int CENTER       = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [1:0] wr_ch_i,
    input  logic [7:0] wr_pos_i,
    output logic [3:0] servo_out_o,
    output logic       frame_start_o,
    output logic       running_o
);

    localparam int              FC_W     = $clog2(FRAME_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAME_CYCLES - 1);
    localparam logic [7:0]      SLEW_B   = 8'(SLEW);
    localparam logic [7:0]      CENTER_B = 8'(CENTER);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic [7:0]      cur_q [4];
    logic [7:0]      cur_d [4];
    logic [7:0]      tgt_q [4];
    logic [31:0]     width_q [4];
    logic [31:0]     width_d [4];
    logic [3:0]      servo_q, servo_d;
    logic            frame_start_q, frame_start_d;
    logic            running_q, running_d;
    logic            wr_ready_q, wr_ready_d;
    logic            last_cycle;
    logic [31:0]     fc_ext;

    function automatic logic [7:0] slew_next(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        diff = 8'd0;
        if (cur < tgt) begin
            diff = tgt - cur;
            return cur + ((diff > SLEW_B) ? SLEW_B : diff);
        end else begin
            diff = cur - tgt;
            return cur - ((diff > SLEW_B) ? SLEW_B : diff);
        end
    endfunction

    always_comb begin
        state_d       = state_q;
        fc_d          = fc_q;
        frame_start_d = 1'b0;
        last_cycle    = (state_q == S_RUN) && (fc_q == FC_LAST);

        case (state_q)
            S_IDLE: begin
                fc_d = '0;
                if (enable_i) begin
                    state_d       = S_RUN;
                    frame_start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (last_cycle) begin
                    fc_d = '0;
                    if (enable_i) begin
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    fc_d = fc_q + FC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                fc_d    = '0;
            end
        endcase

        running_d  = (state_d == S_RUN);
        wr_ready_d = !((state_d == S_RUN) && (fc_d == FC_LAST));
        fc_ext     = 32'(fc_d);

        // Outputs are computed from next-state values so the registered pulse
        // edges line up with the registered frame counter.
        for (int k = 0; k < 4; k++) begin
            cur_d[k]   = last_cycle ? slew_next(cur_q[k], tgt_q[k]) : cur_q[k];
            width_d[k] = frame_start_d ? (32'(MIN_PULSE) + 32'(cur_d[k]) * 32'(STEP))
                                       : width_q[k];
            servo_d[k] = running_d
                         && (fc_ext >= 32'(k * SLOT_CYCLES))
                         && (fc_ext <  32'(k * SLOT_CYCLES) + width_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fc_q          <= '0;
            servo_q       <= '0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
            wr_ready_q    <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                cur_q[k]   <= CENTER_B;
                tgt_q[k]   <= CENTER_B;
                width_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fc_q          <= fc_d;
            servo_q       <= servo_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
            wr_ready_q    <= wr_ready_d;
            for (int k = 0; k < 4; k++) begin
                cur_q[k]   <= cur_d[k];
                width_q[k] <= width_d[k];
            end
            // wr_ready is low on the slew-update cycle, so a write never races the update.
            if (wr_valid_i && wr_ready_q) begin
                tgt_q[wr_ch_i] <= wr_pos_i;
            end
        end
    end

    assign servo_out_o   = servo_q;
    assign frame_start_o = frame_start_q;
    assign running_o     = running_q;
    assign wr_ready_o    = wr_ready_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Scoreboard bench for servo_frame_scheduler with scaled-down frame timing;
// expected pulses are queued per frame and matched by an independent pulse monitor.

module tb_servo_frame_scheduler;

    localparam int FRAME  = 1200;
    localparam int SLOT   = 300;
    localparam int MINP   = 20;
    localparam int STEP   = 1;
    localparam int SLEW   = 16;
    localparam int CENTER = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_ch = 2'd0;
    logic [7:0] wr_pos = 8'd0;
    logic [3:0] servo_out;
    logic       frame_start;
    logic       running;

    servo_frame_scheduler #(
        .FRAME_CYCLES(FRAME),
        .SLOT_CYCLES (SLOT),
        .MIN_PULSE   (MINP),
        .STEP        (STEP),
        .SLEW        (SLEW),
        .CENTER      (CENTER)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_ch_i      (wr_ch),
        .wr_pos_i     (wr_pos),
        .servo_out_o  (servo_out),
        .frame_start_o(frame_start),
        .running_o    (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int off;
        int width;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_cur[4];
    int   m_tgt[4];
    bit   in_run = 1'b0;

    int       mon_fc = 0;
    bit       mon_fs_seen = 1'b0;
    logic [3:0] mon_prev = 4'b0;
    int       mon_rise[4];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int slew_to(input int cur, input int tgt);
        if (cur < tgt) return cur + (((tgt - cur) < SLEW) ? (tgt - cur) : SLEW);
        if (cur > tgt) return cur - (((cur - tgt) < SLEW) ? (cur - tgt) : SLEW);
        return cur;
    endfunction

    task automatic model_slew();
        for (int k = 0; k < 4; k++) m_cur[k] = slew_to(m_cur[k], m_tgt[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_cur[k] = CENTER;
            m_tgt[k] = CENTER;
        end
        in_run = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for a frame start, applies the slew the previous frame ended with,
    // then queues the four pulses this frame should produce.
    task automatic frame_begin();
        int n;
        exp_t e;
        n = 0;
        while (!frame_start && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!frame_start) begin
            fails++;
            $display("FAIL frame_start_wait: got none after %0d cycles, expected a frame start", n);
        end else begin
            if (in_run) model_slew();
            in_run = 1'b1;
            for (int k = 0; k < 4; k++) begin
                e.ch    = k;
                e.off   = k * SLOT;
                e.width = MINP + m_cur[k] * STEP;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_write(input int ch, input int pos);
        int n;
        n = 0;
        wr_ch    = 2'(ch);
        wr_pos   = 8'(pos);
        wr_valid = 1'b1;
        while (!wr_ready && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("write_ready", int'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 1'b0;
        m_tgt[ch] = pos;
    endtask

    // Pulse monitor: measures every servo pulse against the frame start and
    // retires the oldest expected pulse.
    initial begin
        exp_t e;
        for (int k = 0; k < 4; k++) mon_rise[k] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev    = 4'b0;
                mon_fs_seen = 1'b0;
            end else begin
                if (!running) mon_fs_seen = 1'b0;
                if (frame_start) begin
                    if (mon_fs_seen) check("frame_period", mon_fc + 1, FRAME);
                    mon_fc      = 0;
                    mon_fs_seen = 1'b1;
                end else begin
                    mon_fc++;
                end
                for (int k = 0; k < 4; k++) begin
                    if (servo_out[k] && !mon_prev[k]) mon_rise[k] = mon_fc;
                    if (!servo_out[k] && mon_prev[k]) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL pulse_unexpected: got ch %0d off %0d width %0d, expected no pulse",
                                     k, mon_rise[k], mon_fc - mon_rise[k]);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.ch != k || e.off != mon_rise[k] || e.width != mon_fc - mon_rise[k]) begin
                                fails++;
                                $display("FAIL pulse: got ch %0d off %0d width %0d, expected ch %0d off %0d width %0d",
                                         k, mon_rise[k], mon_fc - mon_rise[k], e.ch, e.off, e.width);
                            end
                        end
                    end
                end
                mon_prev = servo_out;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        model_reset();

        #2 rst_n = 1'b0;
        #21;
        check("reset_servo_out", int'(servo_out), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_running", int'(running), 0);
        check("reset_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_neg(3);
        check("idle_running", int'(running), 0);

        enable = 1'b1;
        @(negedge clk);
        check("start_running", int'(running), 1);
        check("start_frame_start", int'(frame_start), 1);
        check("start_servo0", int'(servo_out), 1);

        repeat (3) frame_begin();

        do_write(2, 255);
        repeat (10) frame_begin();

        do_write(1, 0);
        repeat (5) frame_begin();
        do_write(1, 200);
        repeat (11) frame_begin();

        // now at frame cycle 1; hold a write across the slew-update cycle
        wait_neg(FRAME - 3);
        check("ready_before_update", int'(wr_ready), 1);
        @(negedge clk);
        wr_ch    = 2'd3;
        wr_pos   = 8'd100;
        wr_valid = 1'b1;
        check("ready_on_update", int'(wr_ready), 0);
        @(negedge clk);
        check("ready_after_update", int'(wr_ready), 1);
        check("held_write_frame_start", int'(frame_start), 1);
        frame_begin();
        wr_valid = 1'b0;
        m_tgt[3] = 100;
        frame_begin();
        frame_begin();

        // drop enable mid-frame at cycle 360 of this frame
        wait_neg(359);
        enable = 1'b0;
        wait_neg(839);
        check("running_last_cycle", int'(running), 1);
        @(negedge clk);
        check("running_after_frame", int'(running), 0);
        check("no_frame_start_after_drop", int'(frame_start), 0);
        model_slew();
        in_run = 1'b0;
        bad = 0;
        repeat (FRAME + 100) begin
            @(negedge clk);
            if (frame_start || running || servo_out != 4'b0) bad++;
        end
        check("idle_quiet_cycles", bad, 0);

        enable = 1'b1;
        @(negedge clk);
        check("restart_frame_start", int'(frame_start), 1);
        frame_begin();
        frame_begin();

        // reset in the middle of the ch0 pulse (ch0 width 148)
        wait_neg(49);
        check("ch0_high_before_reset", int'(servo_out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_servo_out", int'(servo_out), 0);
        check("async_reset_running", int'(running), 0);
        check("async_reset_wr_ready", int'(wr_ready), 1);
        exp_q.delete();
        model_reset();
        wait_neg(2);
        rst_n = 1'b1;
        frame_begin();
        frame_begin();
        enable = 1'b0;
        wait_neg(FRAME + 20);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_running", int'(running), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
